div_clk_monitor: RTL and testbench
==================================

# div_clk_monitor

- Checks the output of the divide-by-9 clock divider against its expected divide ratio.
- Sits directly downstream of the divider: samples the divided clock in the source `clk` domain and measures its period in source-clock cycles.
- Reports each measured period and declares lock after a run of in-tolerance periods.
- Flags a sticky error on a wrong period or a stalled divider.

## Interface
- `EXP_DIV`, 9, expected period of `div_in` in `clk` cycles
- `TOL`, 0, allowed absolute deviation from `EXP_DIV`, in cycles
- `LOCK_CNT`, 4, consecutive in-tolerance periods required for lock (1..15)
- `CNT_W`, 8, width of period counter and `period` output
- `clk`  in  1  source clock (same clock that drives the divider)
- `rst`  in  1  reset, synchronous, active-low
- `en`  in  1  monitor enable; low forces IDLE
- `clr`  in  1  single-cycle pulse; clears sticky error, restarts acquisition
- `div_in`  in  1  divided clock under test; treated as asynchronous
- `period`  out  CNT_W  last measured period in `clk` cycles
- `period_vld`  out  1  one-cycle pulse when `period` updates
- `locked`  out  1  high while in LOCKED
- `err`  out  1  high while in ERR (sticky)
- `err_cnt`  out  8  count of entries into ERR; saturates at 255

## Operation
- **Input path**
  - Two-flop synchronizer s1→s2, then history flop s3.
  - `rise = s2 & ~s3`. The synchronizer runs regardless of `en`.
- **Period counter** `pcnt` (CNT_W bits)
  - On `rise`: loads 1.
  - Otherwise: increments, saturating at 2^CNT_W−1.
  - `timeout`: `pcnt` equals 2^CNT_W−1 with no `rise`.
  - Cleared to 0 in IDLE.
- **Measurement**
  - On `rise` in ACQ or LOCKED: `period <= pcnt`, `period_vld` pulses.
  - Rises 9 cycles apart give `period` = 9.
  - In tolerance: |period − EXP_DIV| ≤ TOL.
- **States** (binary encoded): IDLE, ARM, ACQ, LOCKED, ERR.
  - IDLE: `en`=1 → ARM.
  - ARM: first `rise` → ACQ with `good_cnt` = 0.
    - No `period` is reported in ARM; the first edge after enable may end a partial period.
    - `timeout` → ERR.
  - ACQ, on each measured period:
    - In tolerance: `good_cnt++`. When `good_cnt` reaches LOCK_CNT → LOCKED.
    - Out of tolerance: `good_cnt` = 0, stay in ACQ.
    - `timeout` → ERR.
  - LOCKED: an out-of-tolerance period or `timeout` → ERR.
  - ERR: holds until `clr` → ARM (`pcnt` and `good_cnt` cleared), or `en`=0 → IDLE.
- **Priority within a cycle:** `rst` > `en`=0 > `clr` > error/lock events.
  - `clr` in a non-ERR state also restarts at ARM.
  - An error event coinciding with `clr` is discarded.
- `err_cnt` increments on every transition into ERR and is cleared only by `rst`.
- `period_vld` and ERR entry may fire in the same cycle; the bad `period` is still reported.

## Timing
- **Reset** (`rst`=0 at a `clk` edge):
  - state IDLE; s1–s3, `pcnt`, `good_cnt` = 0.
  - `period` = 0, `period_vld` = 0, `locked` = 0, `err` = 0, `err_cnt` = 0.
  - Reset mid-operation takes effect at that edge, in any state.
- **Edge latency:** `div_in` first sampled high at edge k → `rise` during cycle k+1..k+2 → `period`/`period_vld` registered at edge k+2.
- `locked`, `err` and `period_vld` are registered and change at the same edge as the state transition.
- `en` falling → IDLE at the next edge; `locked`/`err` low after that edge. The stored `period` value is held.
- **`div_in` pulse width:** high and low phases must each be ≥ 2 `clk` cycles to be detected; narrower pulses are not guaranteed. Each phase of the divide-by-9 output is at least 2 cycles.
- **Stall detection:** `timeout` asserts 2^CNT_W−1 cycles after the last `rise`, i.e. 255 cycles at default CNT_W.

## Test plan
- **Clean lock:** release reset, `en`=1, `div_in` period 9.
  - First `period_vld` at the 2nd rise with `period`=9.
  - `locked`=1 after the 5th rise (4 good periods); `err`=0.
- **Wrong period in LOCKED:** with lock held, one period of 10.
  - `period`=10, `period_vld`, `err`=1, `locked`=0, `err_cnt`=1 at the same edge.
  - `clr` pulse → ARM; relock after 5 more rises.
- **Bad period during ACQ:** periods 9, 9, 8, 9…
  - `good_cnt` resets at the 8.
  - Lock only after 4 further consecutive 9s.
- **Stall:** hold `div_in` low after lock.
  - ERR 255 cycles after the last rise; no `period_vld`; `err_cnt` increments.
- **Disable and re-enable:** `en`=0 mid-lock.
  - IDLE next edge, `locked`=0.
  - Re-enable mid-period: first partial period not reported; first reported `period`=9.
- **Priority:** `clr` in the same cycle as a bad period → ARM, `err` stays 0, `err_cnt` unchanged. `rst`=0 asserted together with `clr` and `en` → all outputs zero at that edge.

Source files
------------

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures the divided clock's period in clk cycles and tracks lock/error against EXP_DIV
// Ports:
//   clk        source clock that also drives the divider
//   rst        synchronous active-low reset
//   en         monitor enable; low forces IDLE
//   clr        single-cycle pulse; clears sticky error, restarts acquisition
//   div_in     divided clock under test (asynchronous)
//   period     last measured period in clk cycles
//   period_vld one-cycle pulse when period updates
//   locked     high while locked
//   err        high while in sticky error
//   err_cnt    saturating count of error entries
module div_clk_monitor #(
    parameter int unsigned EXP_DIV  = 9,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
);
    typedef enum logic [2:0] {IDLE, ARM, ACQ, LOCKED, ERR} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state, state_nxt;
    logic s1, s2, s3;
    logic [CNT_W-1:0] pcnt, pcnt_nxt;
    logic [3:0] good_cnt, good_nxt;
    logic [31:0] p32;
    logic rise, timeout, in_tol, meas;
    assign rise    = s2 & ~s3;
    assign timeout = pcnt == CNT_MAX && !rise;
    assign p32     = 32'(pcnt);
    assign in_tol  = (p32 + TOL >= EXP_DIV) && (p32 <= EXP_DIV + TOL);
    assign meas    = en && rise && (state == ACQ || state == LOCKED);
    assign locked  = state == LOCKED;
    assign err     = state == ERR;
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        pcnt_nxt  = rise ? CNT_W'(1) : (pcnt == CNT_MAX ? pcnt : pcnt + 1'b1);
        case (state)
            IDLE: begin
                state_nxt = ARM;
                pcnt_nxt  = '0;
            end
            ARM: begin
                state_nxt = rise ? ACQ : (timeout ? ERR : ARM);
                good_nxt  = rise ? '0 : good_cnt;
            end
            ACQ: begin
                if (meas) begin
                    good_nxt  = in_tol ? good_cnt + 4'd1 : '0;
                    state_nxt = (32'(good_nxt) == LOCK_CNT) ? LOCKED : ACQ;
                end else if (timeout) begin
                    state_nxt = ERR;
                end
            end
            LOCKED: state_nxt = ((meas && !in_tol) || timeout) ? ERR : LOCKED;
            ERR: state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
        // clr overrides (and so discards) any error event in the same cycle
        if (clr) begin
            state_nxt = ARM;
            pcnt_nxt  = '0;
            good_nxt  = '0;
        end
        if (!en) begin
            state_nxt = IDLE;
            pcnt_nxt  = '0;
            good_nxt  = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            {s1, s2, s3} <= '0;
            state        <= IDLE;
            pcnt         <= '0;
            good_cnt     <= '0;
            period       <= '0;
            period_vld   <= 1'b0;
            err_cnt      <= '0;
        end else begin
            {s1, s2, s3} <= {div_in, s1, s2};
            state        <= state_nxt;
            pcnt         <= pcnt_nxt;
            good_cnt     <= good_nxt;
            period_vld   <= meas;
            if (meas)
                period <= pcnt;
            if (state_nxt == ERR && state != ERR && err_cnt != 8'hff)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: directed and random checks of div_clk_monitor against a timestamp-based reference model
module tb_div_clk_monitor;
    localparam int EXP = 9;
    localparam int TOL = 0;
    localparam int IDLE = 0, ARM = 1, ACQ = 2, LOCKED = 3, ERR = 4;
    logic clk = 1'b0, rst = 1'b0, en = 1'b0, clr = 1'b0, div_in = 1'b0;
    logic [7:0] period, err_cnt;
    logic period_vld, locked, err;
    int total = 0, bad = 0;
    int e = -1, st = IDLE, o = 0, v = 0, good = 0, x_period = 0, x_errcnt = 0;
    bit x_vld = 1'b0;
    bit samp [0:65535];

    always #5 clk = ~clk;

    div_clk_monitor dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .div_in(div_in),
        .period(period), .period_vld(period_vld), .locked(locked),
        .err(err), .err_cnt(err_cnt)
    );

    function automatic bit sv(int i);
        return i < 0 ? 1'b0 : samp[i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a rise lands two edges after div_in is first sampled high; the
    // period counter value is derived from the edge number of its last reload.
    task automatic model();
        bit rs, to, ok, vld;
        int cnt, nst, dev;
        e++;
        samp[e] = div_in;
        if (!rst) begin
            samp[e] = 1'b0;
            if (e > 0) samp[e-1] = 1'b0;
            st = IDLE; o = e; v = 0; good = 0;
            x_period = 0; x_vld = 1'b0; x_errcnt = 0;
        end else begin
            rs  = sv(e-2) && !sv(e-3);
            cnt = v + (e - 1 - o);
            if (cnt > 255) cnt = 255;
            dev = cnt > EXP ? cnt - EXP : EXP - cnt;
            ok  = dev <= TOL;
            vld = en && rs && (st == ACQ || st == LOCKED);
            to  = cnt == 255 && !rs;
            nst = st;
            case (st)
                IDLE: nst = ARM;
                ARM: begin
                    if (rs) begin nst = ACQ; good = 0; end
                    else if (to) nst = ERR;
                end
                ACQ: begin
                    if (vld) begin
                        good = ok ? good + 1 : 0;
                        if (good == 4) nst = LOCKED;
                    end else if (to) nst = ERR;
                end
                LOCKED: if ((vld && !ok) || to) nst = ERR;
                default: nst = st;
            endcase
            if (clr) begin nst = ARM; good = 0; end
            if (!en) begin nst = IDLE; good = 0; end
            if (nst == ERR && st != ERR && x_errcnt < 255) x_errcnt++;
            if (!en || clr || st == IDLE) begin o = e; v = 0; end
            else if (rs) begin o = e; v = 1; end
            x_vld = vld;
            if (vld) x_period = cnt;
            st = nst;
        end
    endtask

    task automatic step(input logic d);
        div_in = d;
        @(posedge clk);
        model();
        #1;
        chk("cycle", 32'({period, period_vld, locked, err, err_cnt}),
            32'({x_period[7:0], x_vld, st == LOCKED, st == ERR, x_errcnt[7:0]}));
    endtask

    task automatic drv(input logic d, input int n);
        for (int i = 0; i < n; i++) step(d);
    endtask

    task automatic per(input int hi, input int lo);
        drv(1'b1, hi);
        drv(1'b0, lo);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step(1'b0);
        clr = 1'b0;
    endtask

    initial begin
        drv(1'b0, 3);
        chk("reset_outs", 32'({period, period_vld, locked, err, err_cnt}), 32'd0);
        rst = 1'b1;
        drv(1'b0, 2);
        en = 1'b1;
        drv(1'b0, 3);
        per(4, 5);
        drv(1'b1, 3);
        chk("first_period", 32'({period_vld, period}), 32'({1'b1, 8'd9}));
        drv(1'b1, 1);
        drv(1'b0, 5);
        per(4, 5);
        per(4, 5);
        chk("no_lock_4rises", 32'(locked), 32'd0);
        per(4, 5);
        chk("lock_5rises", 32'({locked, err}), 32'({1'b1, 1'b0}));
        per(5, 5);
        drv(1'b1, 3);
        chk("bad10", 32'({period, period_vld, err, locked, err_cnt}),
            32'({8'd10, 1'b1, 1'b1, 1'b0, 8'd1}));
        drv(1'b1, 1);
        drv(1'b0, 5);
        pulse_clr();
        chk("clr_err", 32'({err, err_cnt}), 32'({1'b0, 8'd1}));
        for (int i = 0; i < 4; i++) per(4, 5);
        chk("relock_pre", 32'(locked), 32'd0);
        per(4, 5);
        chk("relock", 32'(locked), 32'd1);
        pulse_clr();
        per(4, 5);
        per(4, 5);
        per(4, 4);
        for (int i = 0; i < 4; i++) per(4, 5);
        chk("acq_no_lock", 32'(locked), 32'd0);
        per(4, 5);
        chk("acq_lock", 32'(locked), 32'd1);
        drv(1'b0, 248);
        chk("stall_pre", 32'(err), 32'd0);
        drv(1'b0, 1);
        chk("stall_err", 32'({err, locked, err_cnt}), 32'({1'b1, 1'b0, 8'd2}));
        pulse_clr();
        for (int i = 0; i < 5; i++) per(4, 5);
        chk("lock3", 32'(locked), 32'd1);
        en = 1'b0;
        drv(1'b1, 1);
        chk("dis_idle", 32'({locked, err, period}), 32'({1'b0, 1'b0, 8'd9}));
        drv(1'b1, 3);
        drv(1'b0, 2);
        en = 1'b1;
        drv(1'b0, 3);
        per(4, 5);
        drv(1'b1, 3);
        chk("reen_first", 32'({period_vld, period}), 32'({1'b1, 8'd9}));
        drv(1'b1, 1);
        drv(1'b0, 5);
        for (int i = 0; i < 3; i++) per(4, 5);
        chk("lock4", 32'(locked), 32'd1);
        per(5, 5);
        drv(1'b1, 2);
        clr = 1'b1;
        step(1'b1);
        clr = 1'b0;
        chk("clr_prio", 32'({err, locked, err_cnt}), 32'({1'b0, 1'b0, 8'd2}));
        drv(1'b1, 1);
        drv(1'b0, 5);
        rst = 1'b0;
        clr = 1'b1;
        step(1'b0);
        chk("rst_prio", 32'({period, period_vld, locked, err, err_cnt}), 32'd0);
        rst = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < 80; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            en = r != 0;
            if (r == 1) pulse_clr();
            if (r == 2) drv(1'b0, int'($urandom_range(250, 262)));
            if (r < 6) per(int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
            else per(4, 5);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
